seg_scan_ctrl: RTL

Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display. It shares one hex-to-segment decoder across all digits by stepping through them at a fixed rate. Digit data is double-buffered, so a new value loaded by the host is shown only from the start of a frame. It sits between register/CPU-side display data and the board's `an`/`seg`/`dp` pins.

---
 rtl/seg_pkg.sv | 32 +++
 rtl/seg_hex_decode.sv | 32 +++
 rtl/seg_scan_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// lzb_mask is only referenced when SEG_LZB_EN is defined (leading-zero blanking).
package seg_pkg;

  localparam int unsigned SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam int unsigned MAX_DIGITS = 8;

  typedef logic [3:0] hex_t;

  // Returns a mask of digits to blank: walking down from the top digit, enabled digits holding
  // a 0 nibble with dp off are blanked until the first one that is not. Digit 0 always shows.
  function automatic logic [MAX_DIGITS-1:0] lzb_mask(
    input logic [4*MAX_DIGITS-1:0] data,
    input logic [MAX_DIGITS-1:0]   dps,
    input logic [MAX_DIGITS-1:0]   ens,
    input int unsigned             digits
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  run;
    mask = '0;
    run  = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < int'(digits) && ens[i] && run) begin
        if (data[4*i +: 4] == 4'h0 && !dps[i]) mask[i] = 1'b1;
        else run = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-low 7-segment pattern, segment a at bit 6 through g at bit 0.
module seg_hex_decode
  import seg_pkg::*;
(
  input  hex_t             hex_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (hex_i)
      4'h0:    seg_o = 7'b0000001;
      4'h1:    seg_o = 7'b1001111;
      4'h2:    seg_o = 7'b0010010;
      4'h3:    seg_o = 7'b0000110;
      4'h4:    seg_o = 7'b1001100;
      4'h5:    seg_o = 7'b0100100;
      4'h6:    seg_o = 7'b0100000;
      4'h7:    seg_o = 7'b0001111;
      4'h8:    seg_o = 7'b0000000;
      4'h9:    seg_o = 7'b0000100;
      4'hA:    seg_o = 7'b0001000;
      4'hB:    seg_o = 7'b1100000;
      4'hC:    seg_o = 7'b0110001;
      4'hD:    seg_o = 7'b1000010;
      4'hE:    seg_o = 7'b0110000;
      4'hF:    seg_o = 7'b0111000;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous double-buffered digit data.
// Define SEG_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [4*DIGITS-1:0] data_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   en_in,
  input  logic                load,
  output logic                pending,
  output logic [DIGITS-1:0]   an,
  output logic [SEG_W-1:0]    seg,
  output logic                dp,
  output logic                frame_tick
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = $clog2(DIGITS);
  localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                pending_q, pending_d;
  logic [4*DIGITS-1:0] sh_data_q, sh_data_d, act_data_q, act_data_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   sh_en_q, sh_en_d, act_en_q, act_en_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                tick_q;

  logic slot_end, frame_end;
  assign slot_end  = (cnt_q == CntLast);
  assign frame_end = slot_end && (idx_q == IdxLast);

  always_comb begin
    cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    pending_d  = pending_q;
    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    sh_en_d    = sh_en_q;
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    act_en_d   = act_en_q;
    if (slot_end) idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    if (load) begin
      sh_data_d = data_in;
      sh_dp_d   = dp_in;
      sh_en_d   = en_in;
      pending_d = 1'b1;
    end
    if (frame_end) begin
      pending_d = 1'b0;
      // A load landing on the boundary bypasses the shadow so it is shown this frame.
      if (load) begin
        act_data_d = data_in;
        act_dp_d   = dp_in;
        act_en_d   = en_in;
      end else if (pending_q) begin
        act_data_d = sh_data_q;
        act_dp_d   = sh_dp_q;
        act_en_d   = sh_en_q;
      end
    end
  end

  hex_t             cur_hex;
  logic             cur_en, cur_dp, cur_blank;
  logic [SEG_W-1:0] dec_seg;

  assign cur_hex = act_data_q[{idx_q, 2'b00} +: 4];
  assign cur_en  = act_en_q[idx_q];
  assign cur_dp  = act_dp_q[idx_q];

`ifdef SEG_LZB_EN
  localparam int unsigned PadW = 4 * MAX_DIGITS;
  logic [MAX_DIGITS-1:0] blank_mask;
  assign blank_mask = lzb_mask(PadW'(act_data_q), MAX_DIGITS'(act_dp_q),
                               MAX_DIGITS'(act_en_q), DIGITS);
  assign cur_blank  = blank_mask[idx_q];
`else
  assign cur_blank  = 1'b0;
`endif

  seg_hex_decode u_dec (
    .hex_i(cur_hex),
    .seg_o(dec_seg)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (cur_en && !cur_blank) begin
      an_d[idx_q] = 1'b0;
      seg_d       = dec_seg;
      dp_d        = ~cur_dp;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_en_q    <= '0;
      act_data_q <= '0;
      act_dp_q   <= '0;
      act_en_q   <= '0;
      an_q       <= '1;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      sh_en_q    <= sh_en_d;
      act_data_q <= act_data_d;
      act_dp_q   <= act_dp_d;
      act_en_q   <= act_en_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      tick_q     <= frame_end;
    end
  end

  assign pending    = pending_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule
